any1_wb_sram: RTL and testbench

- 128-bit WISHBONE responder: on-chip scratchpad SRAM in the any1 MPU address map, the target end of the CPU's initiator bus.
- Serves classic single cycles and incrementing bursts, linear or wrapped, driven by cti/bte.
- Raises bok_o so the initiator may burst; signals err_o for reserved cycle types.

---
 rtl/any1_wb_pkg.sv | 20 ++
 rtl/any1_sram_bytewr.sv | 25 ++
 rtl/any1_wb_sram.sv | 104 ++++++++++
 tb/tb_any1_wb_sram.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/any1_wb_pkg.sv
// any1_wb_pkg: WISHBONE cycle/burst encodings, responder states and the burst
// address stepping shared by the any1 scratchpad SRAM.
package any1_wb_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [2:0] {IDLE, CLASSIC, BURST, DROP, ERR} state_t;

   // Wrapped bursts only step the low log2(N) bits; the rest stays put.
   function automatic logic [31:0] burst_nxt(input logic [31:0] a, input logic [1:0] bte);
      logic [31:0] m;
      m = (bte == BTE_LINEAR) ? '1 : (32'd2 << bte) - 32'd1;
      return (a & ~m) | ((a + 32'd1) & m);
   endfunction
endpackage

// File: rtl/any1_sram_bytewr.sv
// any1_sram_bytewr: 2**AW x 128-bit single-port RAM with per-byte write enables
// and a registered read port (contents survive reset, only the read register clears).
module any1_sram_bytewr #(
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [15:0]   be_i,
   input  logic [AW-1:0] adr_i,
   input  logic [127:0]  dat_i,
   output logic [127:0]  dat_o
);
   logic [127:0] mem [2**AW];
   logic [127:0] dat_q;

   always_ff @(posedge clk_i)
      for (int i = 0; i < 16; i++)
         if (be_i[i]) mem[adr_i][8*i +: 8] <= dat_i[8*i +: 8];

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) dat_q <= '0;
      else dat_q <= mem[adr_i];

   assign dat_o = dat_q;
endmodule

// File: rtl/any1_wb_sram.sv
// any1_wb_sram: 128-bit WISHBONE scratchpad responder with classic, linear and wrapped bursts.
// Define ANY1_SRAM_OREG_EN to add an output register on read data (2-clock first read ack).
module any1_wb_sram
   import any1_wb_pkg::*;
#(
   parameter logic [19:0] BASE = 20'hFFD00,
   parameter int          AW   = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cyc_i,
   input  logic         stb_i,
   input  logic         we_i,
   input  logic [15:0]  sel_i,
   input  logic [31:0]  adr_i,
   input  logic [2:0]   cti_i,
   input  logic [1:0]   bte_i,
   input  logic [127:0] dat_i,
   output logic [127:0] dat_o,
   output logic         ack_o,
   output logic         err_o,
   output logic         bok_o
);
   state_t        state_q;
   logic [AW-1:0] ba_q, wa, nxt1, ram_adr;
   logic          f_q, bok_q, cs, go, ack, wr;
   logic [15:0]   be;
   logic [127:0]  ram_q;
   logic          unused_adr;

   assign unused_adr = ^adr_i[3:0];
   assign wa   = adr_i[AW+3:4];
   assign cs   = adr_i[31:AW+4] == BASE[19:AW-8];
   assign go   = cyc_i & stb_i & cs;
   assign nxt1 = AW'(burst_nxt(32'(ba_q), bte_i));
   // f_q marks the output-register fill cycle; it is never set without the option.
   assign ack  = cyc_i & cs & ~f_q & ((state_q == CLASSIC) | ((state_q == BURST) & stb_i));
   assign wr   = we_i & (((state_q == IDLE) & go & ((cti_i == CTI_CLASSIC) | (cti_i == CTI_EOB)))
                       | ((state_q == BURST) & ack));
   assign be   = {16{wr}} & sel_i;

`ifdef ANY1_SRAM_OREG_EN
   localparam bit OREG = 1'b1;
   logic [AW-1:0] nxt2;
   logic [127:0]  dat_q;
   assign nxt2 = AW'(burst_nxt(32'(nxt1), bte_i));
   // Two words in flight: dat_q holds beat ba, the RAM already holds ba+1.
   assign ram_adr = (state_q != BURST) ? wa : we_i ? ba_q : ack ? nxt2 : nxt1;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) dat_q <= '0;
      else if (f_q | (ack & ~we_i)) dat_q <= ram_q;
   assign dat_o = dat_q;
`else
   localparam bit OREG = 1'b0;
   // Prefetch the next beat on every acked read so bursts run without bubbles.
   assign ram_adr = (state_q != BURST) ? wa : (we_i | ~ack) ? ba_q : nxt1;
   assign dat_o = ram_q;
`endif

   any1_sram_bytewr #(.AW(AW)) u_ram (
      .clk_i  (clk_i),
      .rst_ni (rst_i),
      .be_i   (be),
      .adr_i  (ram_adr),
      .dat_i  (dat_i),
      .dat_o  (ram_q)
   );

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q <= IDLE;
         ba_q    <= '0;
         f_q     <= 1'b0;
         bok_q   <= 1'b0;
      end else begin
         bok_q <= 1'b1;
         case (state_q)
            IDLE:
               if (go) begin
                  ba_q    <= wa;
                  f_q     <= OREG & ~we_i;
                  state_q <= ((cti_i == CTI_CLASSIC) || (cti_i == CTI_EOB)) ? CLASSIC
                           : (cti_i == CTI_INCR) ? BURST : ERR;
               end
            CLASSIC, BURST:
               if (!cyc_i) begin
                  state_q <= IDLE;
                  f_q     <= 1'b0;
               end else if (f_q) f_q <= 1'b0;
               else if (ack) begin
                  ba_q <= nxt1;
                  if ((state_q == CLASSIC) || (cti_i == CTI_EOB)) state_q <= DROP;
               end
            DROP:
               if (!cyc_i || !stb_i) state_q <= IDLE;
            default:
               state_q <= DROP;
         endcase
      end

   assign ack_o = ack;
   assign err_o = state_q == ERR;
   assign bok_o = bok_q;
endmodule

// File: tb/tb_any1_wb_sram.sv
// tb_any1_wb_sram: directed bench for any1_wb_sram in its default (no output register) build.
module tb_any1_wb_sram;
   logic         clk_i = 1'b0, rst_i = 1'b1, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [15:0]  sel_i = '0;
   logic [31:0]  adr_i = '0;
   logic [2:0]   cti_i = '0;
   logic [1:0]   bte_i = '0;
   logic [127:0] dat_i = '0;
   logic [127:0] dat_o;
   logic         ack_o, err_o, bok_o;
   int           n_cmp = 0, n_bad = 0;

   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

   always #5 clk_i = ~clk_i;

   any1_wb_sram dut (
      .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .sel_i(sel_i), .adr_i(adr_i), .cti_i(cti_i), .bte_i(bte_i), .dat_i(dat_i),
      .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .bok_o(bok_o)
   );

   function automatic logic [127:0] pat(input int i);
      return {16{8'(8'hA0 + i)}};
   endfunction

   function automatic logic [127:0] xw(input int i);
      return {4{32'hC0DE0000 + 32'(i)}};
   endfunction

   // One single-beat cycle with stb held through the cycle after the ack slot.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [15:0] s,
                       input logic [127:0] d, input logic [2:0] c,
                       output logic a1, output logic e1, output logic [127:0] q, output logic a2);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; sel_i = s; dat_i = d; cti_i = c; bte_i = 2'b00;
      @(negedge clk_i);
      a1 = ack_o; e1 = err_o; q = dat_o;
      @(negedge clk_i);
      a2 = ack_o | err_o;
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_reset;
      #2 rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", ack_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
      n_cmp++; if (bok_o !== 1'b0) begin n_bad++; $display("FAIL rst_bok: got %b want 0", bok_o); end
      n_cmp++; if (dat_o !== '0) begin n_bad++; $display("FAIL rst_dat: got %h want 0", dat_o); end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (bok_o !== 1'b1) begin n_bad++; $display("FAIL rst_bok_rel: got %b want 1", bok_o); end
   endtask

   task automatic test_classic;
      logic a1, e1, a2;
      logic [127:0] q;
      xfer(1'b1, 32'hFFD00040, 16'hFFFF, D1, 3'b000, a1, e1, q, a2);
      n_cmp++; if (a1 !== 1'b1) begin n_bad++; $display("FAIL cl_wr_ack: got %b want 1", a1); end
      n_cmp++; if (e1 !== 1'b0) begin n_bad++; $display("FAIL cl_wr_err: got %b want 0", e1); end
      n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL cl_wr_reack: got %b want 0", a2); end
      xfer(1'b0, 32'hFFD00040, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if (a1 !== 1'b1) begin n_bad++; $display("FAIL cl_rd_ack: got %b want 1", a1); end
      n_cmp++; if (q !== D1) begin n_bad++; $display("FAIL cl_rd_dat: got %h want %h", q, D1); end
      n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL cl_rd_reack: got %b want 0", a2); end
      xfer(1'b0, 32'hFFD00040, 16'hFFFF, '0, 3'b111, a1, e1, q, a2);
      n_cmp++; if (a1 !== 1'b1 || q !== D1) begin n_bad++; $display("FAIL cl_eob_rd: got ack %b dat %h want 1 %h", a1, q, D1); end
   endtask

   task automatic test_byte_lanes;
      logic a1, e1, a2;
      logic [127:0] q;
      xfer(1'b1, 32'hFFD00050, 16'hFFFF, '1, 3'b000, a1, e1, q, a2);
      xfer(1'b1, 32'hFFD00050, 16'h000F, {96'h0, 32'hAA55AA55}, 3'b000, a1, e1, q, a2);
      xfer(1'b0, 32'hFFD00050, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if (q !== {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hAA55AA55}) begin
         n_bad++; $display("FAIL byte_lanes: got %h want ffff..ffff_aa55aa55", q); end
   endtask

   task automatic test_wrap4;
      logic a1, e1, a2;
      logic [127:0] q;
      int seq [4] = '{7, 4, 5, 6};
      for (int i = 4; i < 8; i++) xfer(1'b1, 32'hFFD00000 + 32'(i * 16), 16'hFFFF, pat(i), 3'b000, a1, e1, q, a2);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hFFD00070; cti_i = 3'b010; bte_i = 2'b01;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL wrap_ack%0d: got %b want 1", k, ack_o); end
         n_cmp++; if (dat_o !== pat(seq[k])) begin n_bad++; $display("FAIL wrap_dat%0d: got %h want %h", k, dat_o, pat(seq[k])); end
         if (k == 3) cti_i = 3'b111;
      end
      @(negedge clk_i);
      n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL wrap_end: got %b want 0", ack_o); end
      cyc_i = 1'b0; stb_i = 1'b0; cti_i = 3'b000; bte_i = 2'b00;
      @(negedge clk_i);
   endtask

   task automatic test_burst_gap;
      logic a1, e1, a2;
      logic [127:0] q;
      xfer(1'b1, 32'hFFD00140, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'hFFD00100; cti_i = 3'b010; bte_i = 2'b00;
      sel_i = 16'hFFFF; dat_i = xw(0);
      @(negedge clk_i);
      n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL gap_ack0: got %b want 1", ack_o); end
      @(negedge clk_i);
      dat_i = xw(1);
      n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL gap_ack1: got %b want 1", ack_o); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         stb_i = 1'b0;
         #1;
         n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL gap_wait%0d: got %b want 0", k, ack_o); end
      end
      @(negedge clk_i);
      stb_i = 1'b1; dat_i = xw(2);
      #1;
      n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL gap_ack2: got %b want 1", ack_o); end
      @(negedge clk_i);
      dat_i = xw(3); cti_i = 3'b111;
      n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL gap_ack3: got %b want 1", ack_o); end
      @(negedge clk_i);
      n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL gap_end: got %b want 0", ack_o); end
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) begin
         xfer(1'b0, 32'hFFD00100 + 32'(i * 16), 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
         n_cmp++; if (q !== xw(i)) begin n_bad++; $display("FAIL gap_rd%0d: got %h want %h", i, q, xw(i)); end
      end
      xfer(1'b0, 32'hFFD00140, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if (q !== '0) begin n_bad++; $display("FAIL gap_past_end: got %h want 0", q); end
   endtask

   task automatic test_err;
      logic a1, e1, a2;
      logic [127:0] q;
      xfer(1'b1, 32'hFFD00030, 16'hFFFF, {8{16'h5A5A}}, 3'b000, a1, e1, q, a2);
      xfer(1'b1, 32'hFFD00030, 16'hFFFF, {8{16'hA5A5}}, 3'b011, a1, e1, q, a2);
      n_cmp++; if (a1 !== 1'b0) begin n_bad++; $display("FAIL err_ack: got %b want 0", a1); end
      n_cmp++; if (e1 !== 1'b1) begin n_bad++; $display("FAIL err_err: got %b want 1", e1); end
      n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL err_second: got %b want 0", a2); end
      xfer(1'b0, 32'hFFD00030, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if (q !== {8{16'h5A5A}}) begin n_bad++; $display("FAIL err_ram: got %h want 5a5a..", q); end
      xfer(1'b0, 32'hFFE00000, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if ({a1, e1, a2} !== 3'b000) begin n_bad++; $display("FAIL nocs: got ack/err/late %b%b%b want 000", a1, e1, a2); end
   endtask

   task automatic test_reset_mid_burst;
      logic a1, e1, a2;
      logic [127:0] q;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hFFD00100; cti_i = 3'b010; bte_i = 2'b00;
      @(negedge clk_i);
      n_cmp++; if (ack_o !== 1'b1 || dat_o !== xw(0)) begin n_bad++; $display("FAIL mid_beat0: got ack %b dat %h want 1 %h", ack_o, dat_o, xw(0)); end
      #2 rst_i = 1'b0;
      #1;
      n_cmp++; if ({ack_o, err_o, bok_o} !== 3'b000) begin n_bad++; $display("FAIL mid_rst: got ack/err/bok %b%b%b want 000", ack_o, err_o, bok_o); end
      cyc_i = 1'b0; stb_i = 1'b0; cti_i = 3'b000;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (bok_o !== 1'b1) begin n_bad++; $display("FAIL mid_bok: got %b want 1", bok_o); end
      xfer(1'b0, 32'hFFD00110, 16'hFFFF, '0, 3'b000, a1, e1, q, a2);
      n_cmp++; if (a1 !== 1'b1 || q !== xw(1)) begin n_bad++; $display("FAIL mid_rd: got ack %b dat %h want 1 %h", a1, q, xw(1)); end
   endtask

   initial begin
      test_reset;
      test_classic;
      test_byte_lanes;
      test_wrap4;
      test_burst_gap;
      test_err;
      test_reset_mid_burst;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
